// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the frame transmitter and receiver.
// Holds the FSM state encoding, framing constants and CRC-32 parameters.
// No logic, no latency, no backpressure of its own.
package eth_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        SFD,
        DST,
        SRC,
        LEN,
        PAY,
        FCS,
        IFG
    } eth_tx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam int          PRE_LEN      = 7;
    localparam int          MAC_BYTES    = 6;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    // Byte idx of a MAC address in wire order (MSB first); idx < MAC_BYTES.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [7:0] idx);
        return 8'(mac >> (8 * (MAC_BYTES - 1 - int'(idx))));
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (no final XOR applied).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_frame_tx.sv
// CPU-loaded Ethernet frame serialiser; ETH_TX_FCS_EN appends a CRC-32 FCS.
// Latency: preamble byte valid the cycle after the start store, then one byte per handshake.
// Backpressure: all tx_* outputs hold and the FSM stalls while tx_ready=0.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_DST     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] MAC_SRC     = 48'h4A6F8A7FAA8F,
    parameter int          MAX_PAYLOAD = 16,
    parameter logic [7:0]  PAY_BASE    = 8'hE0,
    parameter logic [7:0]  LEN_ADDR    = 8'hF1,
    parameter logic [7:0]  CTRL_ADDR   = 8'hF2,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_sof,
    output logic       tx_eof,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(MAX_PAYLOAD);

`ifdef ETH_TX_FCS_EN
    localparam eth_tx_state_e POST_PAY = FCS;
`else
    localparam eth_tx_state_e POST_PAY = IFG;
`endif

    eth_tx_state_e state, nxt_state;
    logic [7:0]    cnt, nxt_cnt, lim, nxt_data, len_reg;
    logic          last, nxt_eof, xfer, start, in_pay;
    logic [8:0]    pay_off;
    logic [7:0]    pay_buf [MAX_PAYLOAD];

    assign xfer    = tx_valid & tx_ready;
    assign start   = we & ~busy & (addr == CTRL_ADDR) & wdata[0];
    assign pay_off = {1'b0, addr} - {1'b0, PAY_BASE};
    assign in_pay  = pay_off < 9'(MAX_PAYLOAD);

    // Buffer and length are only writable between frames.
    always_ff @(posedge clk) begin
        if (we && !busy && in_pay) begin
            pay_buf[pay_off[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg <= '0;
        end else if (we && !busy && addr == LEN_ADDR) begin
            len_reg <= (wdata > 8'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD) : wdata;
        end
    end

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_nxt, fcs_word;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (tx_data),
        .crc_out (crc_nxt)
    );

    // On entry to FCS the last payload byte is still being folded in.
    assign fcs_word = (state == FCS) ? ~crc_q : ~crc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (start) begin
            crc_q <= CRC_INIT;
        end else if (xfer && state inside {DST, SRC, LEN, PAY}) begin
            crc_q <= crc_nxt;
        end
    end
`endif

    always_comb begin
        case (state)
            PRE:      lim = 8'(PRE_LEN);
            DST, SRC: lim = 8'(MAC_BYTES);
            LEN:      lim = 8'd2;
            PAY:      lim = len_reg;
            FCS:      lim = 8'd4;
            IFG:      lim = 8'(IFG_CYCLES);
            default:  lim = 8'd1;
        endcase
        last = (cnt == lim - 8'd1);
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 8'd1;
        if (last) begin
            nxt_cnt = '0;
            case (state)
                PRE:     nxt_state = SFD;
                SFD:     nxt_state = DST;
                DST:     nxt_state = SRC;
                SRC:     nxt_state = LEN;
                LEN:     nxt_state = (len_reg == 8'd0) ? POST_PAY : PAY;
                PAY:     nxt_state = POST_PAY;
                FCS:     nxt_state = IFG;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        nxt_data = 8'h00;
        case (nxt_state)
            PRE: nxt_data = ETH_PREAMBLE;
            SFD: nxt_data = ETH_SFD;
            DST: nxt_data = mac_byte(MAC_DST, nxt_cnt);
            SRC: nxt_data = mac_byte(MAC_SRC, nxt_cnt);
            LEN: nxt_data = (nxt_cnt == 8'd0) ? 8'h00 : len_reg;
            PAY: nxt_data = pay_buf[nxt_cnt[PW-1:0]];
`ifdef ETH_TX_FCS_EN
            FCS: nxt_data = fcs_word[8*nxt_cnt[1:0] +: 8];
`endif
            default: nxt_data = 8'h00;
        endcase
`ifdef ETH_TX_FCS_EN
        nxt_eof = (nxt_state == FCS) && (nxt_cnt == 8'd3);
`else
        nxt_eof = ((nxt_state == PAY) && (nxt_cnt == len_reg - 8'd1)) ||
                  ((nxt_state == LEN) && (nxt_cnt == 8'd1) && (len_reg == 8'd0));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state    <= PRE;
                    cnt      <= '0;
                    tx_data  <= ETH_PREAMBLE;
                    tx_valid <= 1'b1;
                    tx_sof   <= 1'b1;
                    tx_eof   <= 1'b0;
                    busy     <= 1'b1;
                end
            end else if (state == IFG) begin
                state <= nxt_state;
                cnt   <= nxt_cnt;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (xfer) begin
                state    <= nxt_state;
                cnt      <= nxt_cnt;
                tx_data  <= nxt_data;
                tx_valid <= (nxt_state != IFG);
                tx_sof   <= 1'b0;
                tx_eof   <= nxt_eof;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: directed and randomized frames against a byte-list model of the frame.
module tb_eth_frame_tx;

    localparam int         MAXP      = 16;
    localparam logic [7:0] PAY_BASE  = 8'hE0;
    localparam logic [7:0] LEN_ADDR  = 8'hF1;
    localparam logic [7:0] CTRL_ADDR = 8'hF2;

    logic       clk = 1'b0;
    logic       rst_n, we, tx_ready, tx_valid, tx_sof, tx_eof, busy, done;
    logic [7:0] addr, wdata, tx_data;

    always #5 clk = ~clk;

    eth_frame_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .busy     (busy),
        .done     (done)
    );

    logic [47:0] mac_dst = 48'hFFFFFFFFFFFF;
    logic [47:0] mac_src = 48'h4A6F8A7FAA8F;
    logic [7:0]  mbuf [MAXP];
    int          mlen = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx [$];

    int n_assert = 0, n_fail = 0;
    int ncyc = 0, done_cnt = 0, done_cyc = 0, eof_cyc = 0;
    int eof_idx = -1, eof_n = 0, sof_idx = -1, sof_n = 0;
    bit bp = 1'b0;
    bit prev_stall = 1'b0;
    logic [10:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Downstream ready: always 1, or a coin flip per cycle when bp is set.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor, sampled mid-cycle: records transferred bytes and checks stall stability.
    always @(negedge clk) begin
        ncyc++;
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (rst_n && prev_stall)
            check("hold_stable", {21'd0, tx_valid, tx_sof, tx_eof, tx_data}, {21'd0, prev_out});
        if (tx_valid && tx_ready) begin
            rx.push_back(tx_data);
            if (tx_eof) begin
                eof_n++;
                eof_idx = rx.size() - 1;
                eof_cyc = ncyc;
            end
            if (tx_sof) begin
                sof_n++;
                sof_idx = rx.size() - 1;
            end
        end
        prev_stall = rst_n && tx_valid && !tx_ready;
        prev_out   = {tx_valid, tx_sof, tx_eof, tx_data};
    end

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_t_in, crc_t_out;
    logic [7:0]  crc_t_byte;

    eth_crc32_byte u_crc_unit (
        .crc_in  (crc_t_in),
        .data    (crc_t_byte),
        .crc_out (crc_t_out)
    );

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
            else                       c = c >> 1;
        end
        return c;
    endfunction
`endif

    // Expected wire bytes for the current model buffer/length.
    function automatic void build_exp();
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(mac_dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(mac_src[8*i +: 8]);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(mlen));
        for (int i = 0; i < mlen; i++) exp_q.push_back(mbuf[i]);
`ifdef ETH_TX_FCS_EN
        begin
            logic [31:0] crc;
            crc = 32'hFFFFFFFF;
            for (int i = 8; i < exp_q.size(); i++) crc = crc_step(crc, exp_q[i]);
            crc = ~crc;
            for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
        end
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; addr = 8'h00; wdata = 8'h00;
    endtask

    task automatic set_buf(input int i, input logic [7:0] v);
        wr(PAY_BASE + 8'(i), v);
        mbuf[i] = v;
    endtask

    task automatic set_len(input logic [7:0] v);
        wr(LEN_ADDR, v);
        mlen = (v > 8'(MAXP)) ? MAXP : int'(v);
    endtask

    task automatic start_frame();
        rx.delete();
        eof_n = 0; sof_n = 0; eof_idx = -1; sof_idx = -1;
        wr(CTRL_ADDR, 8'h01);
    endtask

    task automatic wait_rx(input string tag, input int n);
        for (int i = 0; i < 2000 && rx.size() < n; i++) tick();
        check(tag, 32'(rx.size() >= n), 32'd1);
    endtask

    task automatic finish_frame(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
        check({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        build_exp();
        check({tag, "_size"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx.size()) check($sformatf("%s_byte%0d", tag, i), {24'd0, rx[i]}, {24'd0, exp_q[i]});
        check({tag, "_eof_count"}, 32'(eof_n), 32'd1);
        check({tag, "_eof_pos"}, 32'(eof_idx), 32'(exp_q.size() - 1));
        check({tag, "_sof_count"}, 32'(sof_n), 32'd1);
        check({tag, "_sof_pos"}, 32'(sof_idx), 32'd0);
        check({tag, "_ifg_len"}, 32'(done_cyc - eof_cyc), 32'd13);
        tick();
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_sof",   {31'd0, tx_sof},   32'd0);
        check("rst_tx_eof",   {31'd0, tx_eof},   32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        rst_n = 1'b1;
        tick();

`ifdef ETH_TX_FCS_EN
        begin
            logic [7:0] digits [9];
            logic [31:0] c;
            c = 32'hFFFFFFFF;
            for (int i = 0; i < 9; i++) digits[i] = 8'h31 + 8'(i);
            for (int i = 0; i < 9; i++) begin
                crc_t_in = c; crc_t_byte = digits[i];
                #1;
                c = crc_t_out;
            end
            check("crc_unit_123456789", ~c, 32'hCBF43926);
        end
`endif

        // Basic frame, with start latency checks.
        set_buf(0, 8'hA1); set_buf(1, 8'hB2); set_buf(2, 8'hC3);
        set_len(8'd3);
        start_frame();
        check("start_valid", {31'd0, tx_valid}, 32'd1);
        check("start_sof",   {31'd0, tx_sof},   32'd1);
        check("start_data",  {24'd0, tx_data},  32'h55);
        check("start_busy",  {31'd0, busy},     32'd1);
        finish_frame("basic");

        // Same frame under random backpressure.
        bp = 1'b1;
        start_frame();
        finish_frame("bp");
        bp = 1'b0;

        // Zero length: frame ends on the length byte.
        set_len(8'd0);
        start_frame();
        finish_frame("len0");

        // Length clamp and out-of-window write.
        for (int i = 0; i < MAXP; i++) set_buf(i, 8'($urandom));
        wr(PAY_BASE + 8'(MAXP), ~mbuf[0]);
        set_len(8'hFF);
        bp = 1'b1;
        start_frame();
        finish_frame("clamp");
        bp = 1'b0;

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            int l;
            l = $urandom_range(1, MAXP);
            for (int i = 0; i < l; i++) set_buf(i, 8'($urandom));
            set_len(8'(l));
            bp = 1'($urandom_range(0, 1));
            start_frame();
            finish_frame($sformatf("rand%0d", f));
        end
        bp = 1'b0;

        // Writes and start while busy are ignored.
        for (int i = 0; i < 8; i++) set_buf(i, 8'($urandom_range(1, 255)));
        set_len(8'd8);
        start_frame();
        wait_rx("lock_reach_pay", 22);
        wr(PAY_BASE, 8'h00);
        wr(LEN_ADDR, 8'h01);
        wr(CTRL_ADDR, 8'h01);
        finish_frame("lock");
        rx.delete();
        repeat (20) tick();
        check("lock_no_restart_rx", 32'(rx.size()), 32'd0);
        check("lock_no_restart_busy", {31'd0, busy}, 32'd0);
        start_frame();
        finish_frame("lock_next");

        // Asynchronous reset during DST.
        set_len(8'd6);
        start_frame();
        wait_rx("mid_reach_dst", 10);
        begin
            int d0;
            d0 = done_cnt;
            rst_n = 1'b0;
            #1;
            check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
            check("mid_rst_busy",  {31'd0, busy},     32'd0);
            check("mid_rst_sof",   {31'd0, tx_sof},   32'd0);
            check("mid_rst_eof",   {31'd0, tx_eof},   32'd0);
            check("mid_rst_data",  {24'd0, tx_data},  32'd0);
            repeat (3) tick();
            rst_n = 1'b1;
            mlen = 0;
            repeat (20) tick();
            check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        end
        set_len(8'd6);
        start_frame();
        finish_frame("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
